// File: rtl/mod_updown_tcounter_pkg.sv
// -----------------------------------------------------------------------------
// mod_updown_tcounter_pkg
// Shared constants for the modulo-M up/down toggle counter.
//   MODE_WRAP / MODE_SAT : encoding of the 'mode' input
//   DIR_DOWN / DIR_UP    : encoding of the 'dir' input
//   step_e               : classification of what the counter does on an edge
// -----------------------------------------------------------------------------
package mod_updown_tcounter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

    // What a single enabled, non-load edge does to the count.
    typedef enum logic [1:0] {
        STEP_INC      = 2'd0,
        STEP_DEC      = 2'd1,
        STEP_BOUNDARY = 2'd2
    } step_e;

endpackage : mod_updown_tcounter_pkg

// File: rtl/mod_updown_tcounter_t_cell.sv
// -----------------------------------------------------------------------------
// t_cell
// One bit of the counter: a toggle flip-flop with synchronous clear and
// synchronous parallel load.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low clear (highest priority)
//   t     : toggle enable
//   ld    : synchronous load (beats toggle)
//   d     : load value
//   q     : registered bit value
// -----------------------------------------------------------------------------
module t_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    input  logic ld,
    input  logic d,
    output logic q
);

    logic bit_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_q <= 1'b0;
        end else if (ld) begin
            bit_q <= d;
        end else if (t) begin
            bit_q <= ~bit_q;
        end
    end

    assign q = bit_q;

endmodule : t_cell

// File: rtl/mod_updown_tcounter.sv
// -----------------------------------------------------------------------------
// mod_updown_tcounter
// Parametrised modulo-MODULUS up/down counter built from WIDTH toggle cells.
// Supports direction, synchronous clamped parallel load, wrap or saturate at
// the range ends, a combinational terminal-count flag and a registered
// boundary-event pulse.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (beats load and en)
//   en    : count enable
//   dir   : 1 = up, 0 = down
//   mode  : 0 = wrap, 1 = saturate
//   load  : synchronous parallel load of din (clamped to MODULUS-1)
//   din   : load value
//   q     : registered count, always in 0..MODULUS-1
//   tc    : terminal count; next enabled edge is a boundary event
//   ovf   : one-cycle pulse registered on every boundary event
// -----------------------------------------------------------------------------
module mod_updown_tcounter
    import mod_updown_tcounter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    // Arithmetic is one bit wider than q so that MODULUS == 2**WIDTH and
    // q+1 at the top of the range are both representable without aliasing.
    localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MODULUS - 1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH:0]   cnt_ext;
    logic [WIDTH:0]   next_d;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH:0]   din_ext;
    logic             at_max;
    logic             at_min;
    step_e            step;
    logic             ovf_q;
    logic             ovf_d;

    // next_d never exceeds MODULUS-1, so its top bit is structurally zero.
    logic             unused_next_msb;

    assign cnt_ext = {1'b0, cnt_q};
    assign din_ext = {1'b0, din};
    assign at_max  = (cnt_ext == MAX_EXT);
    assign at_min  = (cnt_ext == '0);

    // Classify the edge, then derive the next count from it.
    always_comb begin
        step = STEP_INC;
        if (dir == DIR_UP) begin
            step = at_max ? STEP_BOUNDARY : STEP_INC;
        end else begin
            step = at_min ? STEP_BOUNDARY : STEP_DEC;
        end
    end

    always_comb begin
        next_d = cnt_ext;
        unique case (step)
            STEP_INC: next_d = cnt_ext + 1'b1;
            STEP_DEC: next_d = cnt_ext - 1'b1;
            STEP_BOUNDARY: begin
                if (mode == MODE_WRAP) begin
                    next_d = (dir == DIR_UP) ? '0 : MAX_EXT;
                end else begin
                    next_d = cnt_ext;
                end
            end
            default: next_d = cnt_ext;
        endcase
    end

    assign unused_next_msb = next_d[WIDTH];

    // A bit toggles exactly where the current and next values differ.
    assign toggle = en ? (cnt_q ^ next_d[WIDTH-1:0]) : '0;

    // Out-of-range load values are clamped to the top of the count range.
    always_comb begin
        load_val = din;
        if (din_ext >= MOD_EXT) begin
            load_val = MAX_EXT[WIDTH-1:0];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_cell
            t_cell u_cell (
                .clk   (clk),
                .rst_n (rst_n),
                .t     (toggle[gi]),
                .ld    (load),
                .d     (load_val[gi]),
                .q     (cnt_q[gi])
            );
        end
    endgenerate

    // ovf fires on every enabled boundary edge, including saturated holds.
    assign ovf_d = ~load & en & (step == STEP_BOUNDARY);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign tc  = en & (((dir == DIR_UP) & at_max) | ((dir == DIR_DOWN) & at_min));
    assign q   = cnt_q;
    assign ovf = ovf_q;

endmodule : mod_updown_tcounter

// File: tb/tb_mod_updown_tcounter.sv
module tb_mod_updown_tcounter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       dir;
    logic       mode;
    logic       load;
    logic [3:0] din;
    logic [3:0] q_a;
    logic       tc_a;
    logic       ovf_a;
    logic [3:0] q_b;
    logic       tc_b;
    logic       ovf_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mod_updown_tcounter #(.WIDTH(4), .MODULUS(10)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .dir   (dir),
        .mode  (mode),
        .load  (load),
        .din   (din),
        .q     (q_a),
        .tc    (tc_a),
        .ovf   (ovf_a)
    );

    mod_updown_tcounter #(.WIDTH(4), .MODULUS(16)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .dir   (dir),
        .mode  (mode),
        .load  (load),
        .din   (din),
        .q     (q_b),
        .tc    (tc_b),
        .ovf   (ovf_b)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input int eq, input int eovf, input int etc);
        $display("[%0t] %s: q=%0d ovf=%0d tc=%0d", $time, tag, q_a, ovf_a, tc_a);
        check({tag, ".q"},   8'(q_a),   8'(eq));
        check({tag, ".ovf"}, 8'(ovf_a), 8'(eovf));
        check({tag, ".tc"},  8'(tc_a),  8'(etc));
    endtask

    task automatic chk_b(input string tag, input int eq, input int eovf, input int etc);
        $display("[%0t] %s: q=%0d ovf=%0d tc=%0d", $time, tag, q_b, ovf_b, tc_b);
        check({tag, ".q"},   8'(q_b),   8'(eq));
        check({tag, ".ovf"}, 8'(ovf_b), 8'(eovf));
        check({tag, ".tc"},  8'(tc_b),  8'(etc));
    endtask

    // Hand-computed expectations for 12 up-count edges from 0 in wrap mode.
    int up_q   [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int up_ovf [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    int up_tc  [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    // Five down-count edges from 3 in wrap mode.
    int dn_q   [5]  = '{2, 1, 0, 9, 8};
    int dn_ovf [5]  = '{0, 0, 0, 1, 0};
    int dn_tc  [5]  = '{0, 0, 1, 0, 0};

    initial begin
        rst_n = 1'b0; en = 1'b0; dir = 1'b1; mode = 1'b0; load = 1'b0; din = 4'd0;
        #1;

        // Reset
        step();
        chk_a("reset", 0, 0, 0);
        chk_b("reset_b", 0, 0, 0);

        // Up count, wrap
        rst_n = 1'b1; en = 1'b1; dir = 1'b1; mode = 1'b0;
        #1;
        check("pre_up.tc", 8'(tc_a), 8'd0);
        for (int i = 0; i < 12; i++) begin
            step();
            chk_a($sformatf("up%0d", i), up_q[i], up_ovf[i], up_tc[i]);
        end

        // Load 3 then down count, wrap
        load = 1'b1; din = 4'd3;
        step();
        chk_a("load3", 3, 0, 0);
        load = 1'b0; dir = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_a($sformatf("dn%0d", i), dn_q[i], dn_ovf[i], dn_tc[i]);
        end

        // Saturate up from 8
        mode = 1'b1; dir = 1'b1; load = 1'b1; din = 4'd8;
        step();
        chk_a("sat_load8", 8, 0, 0);
        load = 1'b0;
        step();
        chk_a("sat_up0", 9, 0, 1);
        step();
        chk_a("sat_up1", 9, 1, 1);
        step();
        chk_a("sat_up2", 9, 1, 1);
        en = 1'b0;
        step();
        chk_a("sat_hold", 9, 0, 0);

        // Saturate down at 0
        load = 1'b1; din = 4'd0;
        step();
        load = 1'b0; en = 1'b1; dir = 1'b0;
        step();
        chk_a("sat_dn0", 0, 1, 1);

        // Clamp on load, load beats en
        mode = 1'b0; dir = 1'b1; load = 1'b1; din = 4'd2;
        step();
        chk_a("load2", 2, 0, 0);
        dir = 1'b0; din = 4'hF;
        step();
        chk_a("clampF", 9, 0, 0);
        din = 4'd10;
        step();
        chk_a("clamp10", 9, 0, 0);

        // Reset wins over load and en
        din = 4'd5;
        step();
        load = 1'b0; dir = 1'b1;
        step();
        chk_a("from5", 6, 0, 0);
        load = 1'b1; din = 4'd0;
        step();
        load = 1'b0; dir = 1'b0;
        step();
        chk_a("pre_rst", 9, 1, 0);
        rst_n = 1'b0; load = 1'b1; din = 4'd7; en = 1'b1;
        step();
        chk_a("rst_wins", 0, 0, 1);
        rst_n = 1'b1; load = 1'b0; dir = 1'b1;
        step();
        chk_a("resume1", 1, 0, 0);
        step();
        chk_a("resume2", 2, 0, 0);

        // MODULUS = 2**WIDTH instance: natural roll-over both ways
        mode = 1'b0; load = 1'b1; din = 4'hF;
        step();
        load = 1'b0; dir = 1'b1;
        #1;
        check("b_tc15", 8'(tc_b), 8'd1);
        step();
        chk_b("b_wrap_up", 0, 1, 0);
        dir = 1'b0;
        step();
        chk_b("b_wrap_dn", 15, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mod_updown_tcounter
